// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter with data mux.
package mux_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns {found, index} of the first set bit scanning upward from start.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   start
    );
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = start + SEL_W'(i);
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4_dp.sv
// Combinational 4:1 data mux selected by the registered grant index.
module mux4_dp (
    input  logic [3:0] in,
    input  logic [1:0] sel,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with hold limit and 4:1 data mux.
// Define MUX_RR_ARBITER_LOCK_EN to add a lock input that suspends expiry.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  in,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic                lock,
`endif
    output logic [NUM_REQ-1:0]  grant,
    output logic [SEL_W-1:0]    sel,
    output logic                out,
    output logic                valid
);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_hold_cnt;

    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]   w_start;
    logic [SEL_W:0]     w_pick;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic               w_expired;
    logic               w_keep;
    logic               w_mux;

    assign w_start   = (r_state == GRANT) ? r_sel + 1'b1 : r_ptr;
    assign w_pick    = rr_pick(req, w_start);
    assign w_found   = w_pick[SEL_W];
    assign w_idx     = w_pick[SEL_W-1:0];
    assign w_expired = (r_hold_cnt >= CNT_W'(HOLD_MAX));

`ifdef MUX_RR_ARBITER_LOCK_EN
    assign w_keep = req[r_sel] && (!w_expired || lock);
`else
    assign w_keep = req[r_sel] && !w_expired;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_hold_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = NUM_REQ'(1) << w_idx;
                    w_sel_nxt   = w_idx;
                    w_ptr_nxt   = w_idx + 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (w_keep) begin
                    // Saturates at HOLD_MAX while locked
                    if (!w_expired)
                        w_cnt_nxt = r_hold_cnt + 1'b1;
                end else if (w_found) begin
                    w_grant_nxt = NUM_REQ'(1) << w_idx;
                    w_sel_nxt   = w_idx;
                    w_ptr_nxt   = w_idx + 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_cnt_nxt;
        end
    end

    mux4_dp u_mux (
        .in  (in),
        .sel (r_sel),
        .out (w_mux)
    );

    assign grant = r_grant;
    assign sel   = r_sel;
    assign valid = (r_state == GRANT);
    assign out   = valid & w_mux;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed steps queue expectations, a monitor checks them.
module tb_mux_rr_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
        logic       o;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] in;
    logic       lock_s;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out;
    logic       valid;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    mux_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .in    (in),
`ifdef MUX_RR_ARBITER_LOCK_EN
        .lock  (lock_s),
`endif
        .grant (grant),
        .sel   (sel),
        .out   (out),
        .valid (valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs and queue what the outputs must show after the next edge.
    task automatic step(
        input logic       rst,
        input logic [3:0] r,
        input logic [3:0] d,
        input logic       l,
        input logic [3:0] eg,
        input logic [1:0] es,
        input logic       ev,
        input logic       eo,
        input string      nm
    );
        exp_t e;
        @(negedge clock);
        reset  = rst;
        req    = r;
        in     = d;
        lock_s = l;
        e.g = eg;
        e.s = es;
        e.v = ev;
        e.o = eo;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(posedge clock) begin
        exp_t  e;
        exp_t  a;
        string nm;
        #2;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.g = grant;
            a.s = sel;
            a.v = valid;
            a.o = out;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got grant=%b sel=%0d valid=%b out=%b, want grant=%b sel=%0d valid=%b out=%b",
                         nm, a.g, a.s, a.v, a.o, e.g, e.s, e.v, e.o);
            end
        end
    end

    initial begin
        logic [3:0] d;
        d = 4'b1011;
        reset  = 1'b1;
        req    = '0;
        in     = '0;
        lock_s = 1'b0;

        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "reset0");
        step(1, 4'b1111, 4'b1111, 0, 4'b0000, 2'd0, 0, 0, "reset1");

        step(0, 4'b0100, d, 0, 4'b0100, 2'd2, 1, 0, "single");
        step(0, 4'b0000, d, 0, 4'b0000, 2'd2, 0, 0, "idle_sel_hold");

        step(1, 4'b0000, d, 0, 4'b0000, 2'd0, 0, 0, "reset_rr");
        for (int h = 0; h < 4; h++)
            for (int k = 0; k < 4; k++)
                step(0, 4'b1111, d, 0, 4'b0001 << h, 2'(h), 1, d[h], "rr");
        step(0, 4'b1111, d, 0, 4'b0001, 2'd0, 1, 1, "rr_wrap");

        step(1, 4'b1111, d, 0, 4'b0000, 2'd0, 0, 0, "reset_midgrant_rr");
        step(0, 4'b0010, d, 0, 4'b0010, 2'd1, 1, 1, "early_g1");
        step(0, 4'b1010, d, 0, 4'b0010, 2'd1, 1, 1, "early_hold");
        step(0, 4'b1000, d, 0, 4'b1000, 2'd3, 1, 1, "early_switch");
        step(0, 4'b0001, d, 0, 4'b0001, 2'd0, 1, 1, "wrap_to0");
        step(0, 4'b0000, d, 0, 4'b0000, 2'd0, 0, 0, "wrap_idle");

        step(0, 4'b0100, d, 0, 4'b0100, 2'd2, 1, 0, "pre_reset_g2");
        step(1, 4'b0100, d, 0, 4'b0000, 2'd0, 0, 0, "reset_midgrant");
        step(0, 4'b1001, d, 0, 4'b0001, 2'd0, 1, 1, "restart_r0");
        step(0, 4'b1001, 4'b0000, 0, 4'b0001, 2'd0, 1, 0, "out_follows_in");

        step(1, 4'b0000, d, 0, 4'b0000, 2'd0, 0, 0, "reset_solo");
        for (int k = 0; k < 6; k++)
            step(0, 4'b0001, d, 0, 4'b0001, 2'd0, 1, 1, "solo_regrant");
        step(0, 4'b0011, d, 0, 4'b0001, 2'd0, 1, 1, "solo_then_pair");

`ifdef MUX_RR_ARBITER_LOCK_EN
        step(1, 4'b0000, d, 0, 4'b0000, 2'd0, 0, 0, "reset_lock");
        for (int k = 0; k < 6; k++)
            step(0, 4'b0011, d, 1, 4'b0001, 2'd0, 1, 1, "lock_hold");
        step(0, 4'b0011, d, 0, 4'b0010, 2'd1, 1, 1, "lock_release");
`endif

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
- REQ-001 SHALL have parameter HOLD_MAX, default 4: max consecutive cycles one requester keeps the grant; legal 1..15.
- REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
- REQ-004 SHALL have port req  input  4  per-requester request; bit i = requester i.
- REQ-005 SHALL have port in  input  4  per-requester data bit; in[i] belongs to requester i.
- REQ-006 SHALL have port grant  output  4  registered one-hot grant, or all-zero.
- REQ-007 SHALL have port sel  output  2  registered index of the current or last grantee; drives the 4:1 data mux.
- REQ-008 SHALL have port out  output  1  muxed data: in[sel] when valid, else 0.
- REQ-009 SHALL have port valid  output  1  high while any grant is active.
- REQ-010 SHALL have port lock  input  1  present only when MUX_RR_ARBITER_LOCK_EN is defined.

Function
- REQ-011 SHALL implement two states: IDLE (no grant) and GRANT (one holder).
- REQ-012 SHALL, in IDLE with req != 0, enter GRANT on the next edge.
  - Grantee: first requester found scanning from ptr upward, modulo 4.
  - hold_cnt set to 1.
- REQ-013 SHALL have grant, sel and valid registered, so a grant appears exactly 1 cycle after req is sampled.
- REQ-014 SHALL, in GRANT, keep the holder while req[holder]=1 and hold_cnt < HOLD_MAX, incrementing hold_cnt each cycle.
- REQ-015 SHALL handle release (req[holder]=0) or expiry (hold_cnt = HOLD_MAX) as follows.
  - Next grantee: first requester scanning from holder+1, modulo 4, taken on the same edge with no idle bubble.
  - If no requester is pending, go to IDLE.
- REQ-016 SHALL, on expiry with only the holder requesting, re-grant the holder with hold_cnt reset to 1.
- REQ-017 SHALL set ptr to grantee+1 (mod 4, wraps 3 to 0) whenever a grant is issued.
- REQ-018 SHALL hold sel at the last grantee in IDLE, with grant=0 and valid=0.
- REQ-019 SHALL generate out combinationally from in and the registered sel, gated by valid.
- REQ-020 SHALL keep grant one-hot or zero in every cycle; a requester dropping req loses its grant on the next edge.
- REQ-021 SHALL size hold_cnt to 4 bits, saturating and never wrapping.

Reset
- REQ-022 SHALL, while reset=1 at an edge, force the following regardless of req or lock:
  - state = IDLE, grant = 4'b0000, sel = 2'b00, valid = 0, ptr = 0, hold_cnt = 0.
- REQ-023 SHALL, when reset is asserted mid-grant, clear the grant on that edge; after release, arbitration restarts with requester 0 at highest priority.

Configuration
- REQ-024 SHALL compile the lock feature only when macro MUX_RR_ARBITER_LOCK_EN is defined.
- REQ-025 SHALL, with the macro defined, ignore expiry while lock=1 and req[holder]=1: the holder is kept and hold_cnt saturates at HOLD_MAX.
- REQ-026 SHALL, without the macro, have no lock port and apply expiry unconditionally.

Structure
- REQ-027 SHALL place the following in shared package mux_rr_arbiter_pkg:
  - state enum {IDLE, GRANT};
  - constants NUM_REQ = 4, SEL_W = 2, CNT_W = 4.
- REQ-028 SHALL instantiate one sub-module, mux4_dp: a combinational 4:1 data mux with inputs in[3:0] and sel[1:0], output out.

Verification
- REQ-029 Single requester: after reset, req=4'b0100 held, in=4'b1011 -> one cycle later grant=4'b0100, sel=2'b10, valid=1, out=0.
- REQ-030 Round robin, HOLD_MAX=4, req=4'b1111, in=4'b1011 -> grant order 0,1,2,3,0, each held 4 cycles; out sequence 1,1,0,1.
- REQ-031 Early release: holder 1 drops req after 2 cycles while req[3]=1 -> grant switches 4'b0010 to 4'b1000 on the next edge, no valid gap.
- REQ-032 Wrap and IDLE:
  - holder 3 releases, req=4'b0001 -> grant=4'b0001 next edge;
  - then req=0 -> valid=0, grant=0, sel stays 2'b00.
- REQ-033 Reset mid-grant: reset=1 during grant=4'b0100 -> next edge grant=0, valid=0, sel=2'b00; after release with req=4'b1001 -> grant=4'b0001.
- REQ-034 With MUX_RR_ARBITER_LOCK_EN, lock=1, req=4'b0011, holder 0 -> grant stays 4'b0001 beyond 4 cycles; lock=0 -> grant=4'b0010 next edge.
